// File: rtl/spi_cmd_decoder.sv
// Framed SPI command decoder: opcode, address, data bytes -> register file strobes,
// with prefetched read data handed back to the SPI shifter one byte ahead.
module spi_cmd_decoder #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              frame_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [7:0]        reg_rdata,
    output logic              reg_we,
    output logic              reg_re,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    output logic              cmd_err
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DRAIN} state_t;

    state_t            state;
    logic              is_read;
    logic              armed;
    logic [ADDR_W-1:0] addr;
    logic              accept;

    assign accept = rx_valid && frame_active;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            is_read   <= 1'b0;
            armed     <= 1'b0;
            addr      <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            tx_data   <= 8'h00;
            tx_load   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            tx_load <= 1'b0;
            cmd_err <= 1'b0;

            // A frame already in progress when reset lifts is never decoded;
            // decoding only starts after the select has been seen idle once.
            if (!frame_active)
                armed <= 1'b1;

            // Register file answers combinationally to the address presented with
            // reg_re; a frame cut in the meantime leaves the shift byte untouched.
            if (reg_re && frame_active) begin
                tx_data <= reg_rdata;
                tx_load <= 1'b1;
            end

            if (!frame_active) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed)
                            state <= CMD;
                    end
                    CMD: begin
                        if (accept) begin
                            case (rx_data)
                                OP_WRITE: begin
                                    is_read <= 1'b0;
                                    state   <= ADDR;
                                end
                                OP_READ: begin
                                    is_read <= 1'b1;
                                    state   <= ADDR;
                                end
                                OP_NOP: state <= DRAIN;
                                default: begin
                                    cmd_err <= 1'b1;
                                    state   <= DRAIN;
                                end
                            endcase
                        end
                    end
                    ADDR: begin
                        if (accept) begin
                            addr <= rx_data[ADDR_W-1:0];
                            if (is_read) begin
                                // Prefetch so the first data byte can return this location.
                                reg_re   <= 1'b1;
                                reg_addr <= rx_data[ADDR_W-1:0];
                                state    <= RDATA;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (accept) begin
                            reg_we    <= 1'b1;
                            reg_addr  <= addr;
                            reg_wdata <= rx_data;
                            addr      <= addr + ADDR_W'(1);
                        end
                    end
                    RDATA: begin
                        if (accept) begin
                            reg_re   <= 1'b1;
                            reg_addr <= addr + ADDR_W'(1);
                            addr     <= addr + ADDR_W'(1);
                        end
                    end
                    DRAIN: state <= DRAIN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: table vectors, corner-case sequences and random frames
// checked against a frame-level transaction model.
module tb_spi_cmd_decoder;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              frame_active = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic [7:0]        reg_rdata;
    logic              reg_we, reg_re, tx_load, cmd_err;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata, tx_data;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_(rst_), .frame_active(frame_active), .rx_valid(rx_valid),
        .rx_data(rx_data), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .tx_data(tx_data),
        .tx_load(tx_load), .cmd_err(cmd_err)
    );

    // Register file harness and the model's own copy of its contents
    logic [7:0] mem [DEPTH];
    logic [7:0] mm  [DEPTH];
    assign reg_rdata = mem[reg_addr];

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reg_we) mem[reg_addr] = reg_wdata;
    end

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        int                c;
    } ev_t;

    ev_t wq[$], rq[$], tq[$];
    int  eq[$];

    initial forever begin
        @(negedge clk);
        if (reg_we)  wq.push_back('{reg_addr, reg_wdata, cyc});
        if (reg_re)  rq.push_back('{reg_addr, 8'h00, cyc});
        if (tx_load) tq.push_back('{'0, tx_data, cyc});
        if (cmd_err) eq.push_back(cyc);
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] fb[$];
    int         acc[$];

    task automatic clear_events();
        wq.delete(); rq.delete(); tq.delete(); eq.delete(); acc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        acc.push_back(cyc);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_active = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame();
        clear_events();
        start_frame();
        foreach (fb[i]) send_byte(fb[i]);
        end_frame();
    endtask

    // Frame-level model: what the accepted bytes of one frame must produce
    task automatic check_frame(input string tag);
        ev_t ew[$], er[$], et[$];
        int  ee[$];
        int  n;
        int  a;
        n = fb.size();
        if (n >= 1 && fb[0] > 8'h02) ee.push_back(acc[0] + 1);
        if (n >= 2 && fb[0] == 8'h01)
            for (int k = 0; k < n - 2; k++) begin
                a = (int'(fb[1]) + k) % DEPTH;
                ew.push_back('{ADDR_W'(a), fb[k+2], acc[k+2] + 1});
                mm[a] = fb[k+2];
            end
        if (n >= 2 && fb[0] == 8'h02)
            for (int k = 0; k < n - 1; k++) begin
                a = (int'(fb[1]) + k) % DEPTH;
                er.push_back('{ADDR_W'(a), 8'h00, acc[k+1] + 1});
                et.push_back('{'0, mm[a], acc[k+1] + 2});
            end
        chk({tag, " we count"}, wq.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
            chk({tag, " we addr"}, wq[i].a, ew[i].a);
            chk({tag, " we data"}, wq[i].d, ew[i].d);
            chk({tag, " we cycle"}, wq[i].c, ew[i].c);
        end
        chk({tag, " re count"}, rq.size(), er.size());
        for (int i = 0; i < er.size() && i < rq.size(); i++) begin
            chk({tag, " re addr"}, rq[i].a, er[i].a);
            chk({tag, " re cycle"}, rq[i].c, er[i].c);
        end
        chk({tag, " tx count"}, tq.size(), et.size());
        for (int i = 0; i < et.size() && i < tq.size(); i++) begin
            chk({tag, " tx data"}, tq[i].d, et[i].d);
            chk({tag, " tx cycle"}, tq[i].c, et[i].c);
        end
        chk({tag, " err count"}, eq.size(), ee.size());
        for (int i = 0; i < ee.size() && i < eq.size(); i++)
            chk({tag, " err cycle"}, eq[i], ee[i]);
    endtask

    typedef struct {
        logic [3:0][7:0]   b;      // b[3] is the first byte on the wire
        int                n;
        int                exp_we;
        logic [ADDR_W-1:0] a0;
        logic [7:0]        d0;
        logic [ADDR_W-1:0] a1;
        logic [7:0]        d1;
        int                exp_re;
        logic [7:0]        tx0;
        logic [7:0]        tx1;
        int                exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check_outputs_zero(input string tag);
        chk({tag, " reg_we"}, reg_we, 0);
        chk({tag, " reg_re"}, reg_re, 0);
        chk({tag, " tx_load"}, tx_load, 0);
        chk({tag, " cmd_err"}, cmd_err, 0);
        chk({tag, " reg_addr"}, reg_addr, 0);
        chk({tag, " reg_wdata"}, reg_wdata, 0);
        chk({tag, " tx_data"}, tx_data, 0);
    endtask

    initial begin
        vecs[0] = '{32'h0110AABB, 4, 2, 7'h10, 8'hAA, 7'h11, 8'hBB, 0, 8'h00, 8'h00, 0};
        vecs[1] = '{32'h02200000, 4, 0, 7'h20, 8'h00, 7'h21, 8'h00, 3, 8'h5A, 8'hC3, 0};
        vecs[2] = '{32'h017F1122, 4, 2, 7'h7F, 8'h11, 7'h00, 8'h22, 0, 8'h00, 8'h00, 0};
        vecs[3] = '{32'h5C10FF00, 3, 0, 7'h00, 8'h00, 7'h00, 8'h00, 0, 8'h00, 8'h00, 1};
        vecs[4] = '{32'h01034400, 3, 1, 7'h03, 8'h44, 7'h00, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[5] = '{32'h00123400, 3, 0, 7'h00, 8'h00, 7'h00, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[6] = '{32'h02000000, 1, 0, 7'h00, 8'h00, 7'h00, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[7] = '{32'h01550000, 2, 0, 7'h00, 8'h00, 7'h00, 8'h00, 0, 8'h00, 8'h00, 0};
        vecs[8] = '{32'h02A00000, 2, 0, 7'h20, 8'h00, 7'h00, 8'h00, 1, 8'h5A, 8'h00, 0};

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;
        for (int i = 0; i < DEPTH; i++) mm[i] = mem[i];

        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[v]) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            fb.delete();
            for (int i = 0; i < vecs[v].n; i++) fb.push_back(vecs[v].b[3-i]);
            send_frame();
            chk({tag, " tbl we"}, wq.size(), vecs[v].exp_we);
            if (vecs[v].exp_we >= 1 && wq.size() >= 1) begin
                chk({tag, " tbl we0 addr"}, wq[0].a, vecs[v].a0);
                chk({tag, " tbl we0 data"}, wq[0].d, vecs[v].d0);
            end
            if (vecs[v].exp_we >= 2 && wq.size() >= 2) begin
                chk({tag, " tbl we1 addr"}, wq[1].a, vecs[v].a1);
                chk({tag, " tbl we1 data"}, wq[1].d, vecs[v].d1);
            end
            chk({tag, " tbl re"}, rq.size(), vecs[v].exp_re);
            chk({tag, " tbl tx"}, tq.size(), vecs[v].exp_re);
            if (vecs[v].exp_re >= 1 && rq.size() >= 1 && tq.size() >= 1) begin
                chk({tag, " tbl re0 addr"}, rq[0].a, vecs[v].a0);
                chk({tag, " tbl tx0"}, tq[0].d, vecs[v].tx0);
            end
            if (vecs[v].exp_re >= 2 && rq.size() >= 2 && tq.size() >= 2) begin
                chk({tag, " tbl re1 addr"}, rq[1].a, vecs[v].a1);
                chk({tag, " tbl tx1"}, tq[1].d, vecs[v].tx1);
            end
            chk({tag, " tbl err"}, eq.size(), vecs[v].exp_err);
            check_frame(tag);
        end

        // Frame cut after opcode+address, with a byte arriving on the drop cycle
        fb = '{8'h01, 8'h08};
        clear_events();
        start_frame();
        foreach (fb[i]) send_byte(fb[i]);
        @(negedge clk);
        frame_active = 1'b0;
        rx_data      = 8'h99;
        rx_valid     = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_frame("drop");
        fb = '{8'h01, 8'h08, 8'h77};
        send_frame();
        check_frame("after drop");

        // Async reset in the middle of a write burst, released while still selected
        fb = '{8'h01, 8'h10, 8'hAA};
        clear_events();
        start_frame();
        foreach (fb[i]) send_byte(fb[i]);
        @(negedge clk);
        #1 rst_ = 1'b0;
        #1 check_outputs_zero("midreset");
        @(negedge clk);
        rst_ = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h12);
        check_frame("midreset");
        end_frame();
        fb = '{8'h01, 8'h05, 8'h66};
        send_frame();
        check_frame("post reset");

        for (int f = 0; f < 40; f++) begin
            int r, n;
            fb.delete();
            r = $urandom_range(0, 9);
            if (r < 4)      fb.push_back(8'h01);
            else if (r < 7) fb.push_back(8'h02);
            else if (r < 8) fb.push_back(8'h00);
            else            fb.push_back(8'($urandom_range(3, 255)));
            n = $urandom_range(1, 6);
            for (int i = 1; i < n; i++) fb.push_back(8'($urandom));
            send_frame();
            check_frame($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
